tmr_voter_monitor: RTL and testbench
====================================

Name: tmr_voter_monitor

Overview:
- Parametrised, registered successor to the bitwise majority voter used at TMR domain boundaries.
- Votes three WIDTH-bit replicas and registers the result.
- Flags which lane disagreed with the vote and keeps saturating per-lane error counters.
- Tracks each lane's health through a per-lane state machine, so persistent upsets are reported separately from single transient upsets.

Parameters:
WIDTH, 8, bit width of each replica bus and of the voted output
CNT_W, 8, width of each per-lane saturating error counter
FAIL_THRESH, 4, consecutive mismatching valid cycles that move a lane to FAILED (legal range 1 to 2^CNT_W-1)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
inA  input  WIDTH  replica A
inB  input  WIDTH  replica B
inC  input  WIDTH  replica C
in_valid  input  1  replicas are valid this cycle
clr_cnt  input  1  clear counters and lane states
out  output  WIDTH  registered bitwise majority of inA/inB/inC
out_valid  output  1  registered copy of in_valid
errA  output  1  pulse: lane A differed from the vote in the last valid cycle (same for errB, errC)
errB  output  1  lane B mismatch pulse
errC  output  1  lane C mismatch pulse
multi_err  output  1  pulse: two or more lanes differed from the vote (in different bits) in the same valid cycle
cntA  output  CNT_W  lane A saturating mismatch count (same for cntB, cntC)
cntB  output  CNT_W  lane B count
cntC  output  CNT_W  lane C count
failA  output  1  lane A in FAILED state (same for failB, failC)
failB  output  1  lane B FAILED
failC  output  1  lane C FAILED

Behaviour:
- Reset: on a cycle with rst=1 all outputs read 0 after the next edge and all lane states go to OK. Reset mid-operation discards in-flight data. rst has priority over every other input.
- Vote: v = (inA&inB)|(inB&inC)|(inA&inC). It is computed bitwise and combinationally from the inputs, then registered. Latency is 1 cycle.
- Valid cycle (in_valid=1):
  - out <= v; out_valid <= 1.
  - mA = |(inA^v); likewise mB and mC.
  - errX <= mX; multi_err <= (mA+mB+mC >= 2).
- Invalid cycle (in_valid=0):
  - out holds its previous value; out_valid <= 0.
  - errX and multi_err <= 0.
  - Counters and lane states are unchanged.
- Counters: cntX increments by 1 per valid cycle with mX=1. It saturates at 2^CNT_W-1 and never wraps.
- Per-lane FSM, with consecutive-mismatch counter runX of width ceil(log2(FAIL_THRESH+1)):
  - OK: if mX, runX<=1. Go to FAILED if FAIL_THRESH==1, otherwise go to SUSPECT.
  - SUSPECT: if mX, runX<=runX+1, and go to FAILED when runX+1==FAIL_THRESH. On a valid cycle with !mX, runX<=0 and go to OK. Invalid cycles hold state and runX.
  - FAILED: sticky, with failX=1. Leaves only via clr_cnt or rst, to OK with runX=0.
- clr_cnt (rst=0):
  - Next cycle: cntX=0, runX=0, all lanes OK, failX=0.
  - Takes priority over a simultaneous mismatch; that cycle's mismatch is not counted.
  - errX, multi_err, out and out_valid still update normally from that cycle's inputs.
- All three lanes equal: no flags; counters and FSMs behave as mismatch-free.

Optional Feature:
- Macro TMR_VOTER_FANOUT_EN.
- Defined:
  - Adds ports outA, outB, outC (output, WIDTH).
  - Each is driven from its own separate register loaded with v under the same valid/hold rules as out, so the voted value re-enters a triplicated domain.
  - Reset value 0.
- Undefined: these ports and registers do not exist, and the rest of the behaviour is identical.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then in_valid=0 -> out=0, out_valid=0, all cnt=0, all fail=0.
- Clean vote: inA=inB=inC=8'h5A, in_valid=1 -> next cycle out=8'h5A, out_valid=1, errA/B/C=0, multi_err=0.
- Single upset: inA=8'h5B, inB=inC=8'h5A for 1 valid cycle -> out=8'h5A, errA=1 for one cycle, cntA=1, failA=0; a following clean valid cycle returns lane A to OK.
- Persistent fault: inB=8'hFF, inA=inC=8'h00 for 4 consecutive valid cycles (FAIL_THRESH=4) -> out=8'h00 throughout, cntB=4, failB=1 after the 4th cycle; inserting an in_valid=0 gap still reaches failB on the 4th mismatch; failB stays 1 after the inputs go clean until clr_cnt=1.
- Multi-lane: inA=8'h01, inB=8'h02, inC=8'h00 -> out=8'h00, errA=errB=1, multi_err=1, cntA=cntB=1, cntC=0.
- Saturation and clear: CNT_W=2, 5 valid cycles with lane C mismatched -> cntC stuck at 3; clr_cnt=1 during a lane-C mismatch -> cntC=0 and failC=0 next cycle, errC=1 for that cycle.

Source files
------------

// File: rtl/tmr_voter_monitor.sv
// Registered bitwise TMR majority voter with per-lane mismatch flags, saturating error counters
// and per-lane health FSMs. Define TMR_VOTER_FANOUT_EN to add triplicated voted outputs.
module tmr_voter_monitor #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned FAIL_THRESH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic [WIDTH-1:0] inC,
    input  logic             in_valid,
    input  logic             clr_cnt,
    output logic [WIDTH-1:0] out,
`ifdef TMR_VOTER_FANOUT_EN
    output logic [WIDTH-1:0] outA,
    output logic [WIDTH-1:0] outB,
    output logic [WIDTH-1:0] outC,
`endif
    output logic             out_valid,
    output logic             errA,
    output logic             errB,
    output logic             errC,
    output logic             multi_err,
    output logic [CNT_W-1:0] cntA,
    output logic [CNT_W-1:0] cntB,
    output logic [CNT_W-1:0] cntC,
    output logic             failA,
    output logic             failB,
    output logic             failC
);

    localparam int unsigned RUN_W = $clog2(FAIL_THRESH + 1);
    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [RUN_W-1:0] RunThresh = RUN_W'(FAIL_THRESH);

    typedef enum logic [1:0] {
        StOk,
        StSuspect,
        StFailed
    } lane_state_e;

    logic [WIDTH-1:0] w_vote;
    logic [2:0]       w_mis;
    logic             w_multi;

    logic [WIDTH-1:0] r_out;
    logic             r_out_valid;
    logic [2:0]       r_err;
    logic             r_multi;
    logic [2:0]       r_fail;
    logic [CNT_W-1:0] r_cnt   [3];
    logic [RUN_W-1:0] r_run   [3];
    lane_state_e      r_state [3];

    assign w_vote = (inA & inB) | (inB & inC) | (inA & inC);
    assign w_mis  = {|(inC ^ w_vote), |(inB ^ w_vote), |(inA ^ w_vote)};
    assign w_multi = (w_mis[0] & w_mis[1]) | (w_mis[1] & w_mis[2]) | (w_mis[0] & w_mis[2]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_err       <= '0;
            r_multi     <= 1'b0;
            r_fail      <= '0;
            for (int i = 0; i < 3; i++) begin
                r_cnt[i]   <= '0;
                r_run[i]   <= '0;
                r_state[i] <= StOk;
            end
        end else begin
            if (in_valid) begin
                r_out       <= w_vote;
                r_out_valid <= 1'b1;
                r_err       <= w_mis;
                r_multi     <= w_multi;
            end else begin
                r_out_valid <= 1'b0;
                r_err       <= '0;
                r_multi     <= 1'b0;
            end

            for (int i = 0; i < 3; i++) begin
                // Clear wins over a same-cycle mismatch, which is then not counted.
                if (clr_cnt) begin
                    r_cnt[i]   <= '0;
                    r_run[i]   <= '0;
                    r_state[i] <= StOk;
                    r_fail[i]  <= 1'b0;
                end else if (in_valid) begin
                    if (w_mis[i] && (r_cnt[i] != CntMax)) begin
                        r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                    end
                    case (r_state[i])
                        StOk: begin
                            if (w_mis[i]) begin
                                r_run[i] <= RUN_W'(1);
                                if (FAIL_THRESH == 1) begin
                                    r_state[i] <= StFailed;
                                    r_fail[i]  <= 1'b1;
                                end else begin
                                    r_state[i] <= StSuspect;
                                end
                            end
                        end
                        StSuspect: begin
                            if (w_mis[i]) begin
                                r_run[i] <= r_run[i] + RUN_W'(1);
                                if ((r_run[i] + RUN_W'(1)) == RunThresh) begin
                                    r_state[i] <= StFailed;
                                    r_fail[i]  <= 1'b1;
                                end
                            end else begin
                                r_run[i]   <= '0;
                                r_state[i] <= StOk;
                            end
                        end
                        StFailed: begin
                            r_fail[i] <= 1'b1;
                        end
                        default: begin
                            r_run[i]   <= '0;
                            r_state[i] <= StOk;
                            r_fail[i]  <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

`ifdef TMR_VOTER_FANOUT_EN
    // Separate registers so the voted value re-enters three independent domains.
    logic [WIDTH-1:0] r_out_a;
    logic [WIDTH-1:0] r_out_b;
    logic [WIDTH-1:0] r_out_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_a <= '0;
            r_out_b <= '0;
            r_out_c <= '0;
        end else if (in_valid) begin
            r_out_a <= w_vote;
            r_out_b <= w_vote;
            r_out_c <= w_vote;
        end
    end

    assign outA = r_out_a;
    assign outB = r_out_b;
    assign outC = r_out_c;
`endif

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign errA      = r_err[0];
    assign errB      = r_err[1];
    assign errC      = r_err[2];
    assign multi_err = r_multi;
    assign cntA      = r_cnt[0];
    assign cntB      = r_cnt[1];
    assign cntC      = r_cnt[2];
    assign failA     = r_fail[0];
    assign failB     = r_fail[1];
    assign failC     = r_fail[2];

endmodule

// File: tb/tb_tmr_voter_monitor.sv
// Directed bench for tmr_voter_monitor: a default instance plus a CNT_W=2, FAIL_THRESH=1
// instance for saturation and single-mismatch-fail boundaries.
module tb_tmr_voter_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] inA, inB, inC;
    logic       in_valid, clr_cnt;

    logic [7:0] out;
    logic       out_valid, errA, errB, errC, multi_err, failA, failB, failC;
    logic [7:0] cntA, cntB, cntC;

    logic [7:0] u2_out;
    logic       u2_out_valid, u2_errA, u2_errB, u2_errC, u2_multi_err;
    logic       u2_failA, u2_failB, u2_failC;
    logic [1:0] u2_cntA, u2_cntB, u2_cntC;

`ifdef TMR_VOTER_FANOUT_EN
    logic [7:0] outA, outB, outC, u2_outA, u2_outB, u2_outC;
`endif

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    tmr_voter_monitor #(.WIDTH(8), .CNT_W(8), .FAIL_THRESH(4)) u_dut (
        .clk(clk), .rst(rst), .inA(inA), .inB(inB), .inC(inC),
        .in_valid(in_valid), .clr_cnt(clr_cnt), .out(out),
`ifdef TMR_VOTER_FANOUT_EN
        .outA(outA), .outB(outB), .outC(outC),
`endif
        .out_valid(out_valid), .errA(errA), .errB(errB), .errC(errC),
        .multi_err(multi_err), .cntA(cntA), .cntB(cntB), .cntC(cntC),
        .failA(failA), .failB(failB), .failC(failC)
    );

    tmr_voter_monitor #(.WIDTH(8), .CNT_W(2), .FAIL_THRESH(1)) u_dut2 (
        .clk(clk), .rst(rst), .inA(inA), .inB(inB), .inC(inC),
        .in_valid(in_valid), .clr_cnt(clr_cnt), .out(u2_out),
`ifdef TMR_VOTER_FANOUT_EN
        .outA(u2_outA), .outB(u2_outB), .outC(u2_outC),
`endif
        .out_valid(u2_out_valid), .errA(u2_errA), .errB(u2_errB), .errC(u2_errC),
        .multi_err(u2_multi_err), .cntA(u2_cntA), .cntB(u2_cntB), .cntC(u2_cntC),
        .failA(u2_failA), .failB(u2_failB), .failC(u2_failC)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs, then return 1 time unit after the capturing edge.
    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input logic v, input logic clr);
        inA      = a;
        inB      = b;
        inC      = c;
        in_valid = v;
        clr_cnt  = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        check_val("reset_out", out, 32'h0);
        check_val("reset_out_valid", out_valid, 32'h0);
        check_val("reset_cnts", {cntA, cntB, cntC}, 32'h0);
        check_val("reset_fails", {failA, failB, failC}, 32'h0);
        check_val("reset_errs", {errA, errB, errC, multi_err}, 32'h0);

        // Clean vote
        drive(8'h5A, 8'h5A, 8'h5A, 1'b1, 1'b0);
        check_val("clean_out", out, 32'h5A);
        check_val("clean_out_valid", out_valid, 32'h1);
        check_val("clean_errs", {errA, errB, errC, multi_err}, 32'h0);

        // Single upset on lane A
        drive(8'h5B, 8'h5A, 8'h5A, 1'b1, 1'b0);
        check_val("upset_out", out, 32'h5A);
        check_val("upset_errs", {errA, errB, errC, multi_err}, 32'b1000);
        check_val("upset_cntA", cntA, 32'd1);
        check_val("upset_failA", failA, 32'h0);
        check_val("thresh1_failA", u2_failA, 32'h1);
        drive(8'h5A, 8'h5A, 8'h5A, 1'b1, 1'b0);
        check_val("recover_errA", errA, 32'h0);
        check_val("recover_cntA", cntA, 32'd1);
        drive(8'h11, 8'h22, 8'h33, 1'b0, 1'b0);
        check_val("hold_out", out, 32'h5A);
        check_val("hold_out_valid", out_valid, 32'h0);

        // Persistent fault on lane B with an invalid gap
        drive(8'h00, 8'hFF, 8'h00, 1'b1, 1'b0);
        check_val("pers1_out", out, 32'h00);
        check_val("pers1_errB", errB, 32'h1);
        check_val("pers1_cntB", cntB, 32'd1);
        drive(8'h00, 8'hFF, 8'h00, 1'b1, 1'b0);
        check_val("pers2_cntB", cntB, 32'd2);
        check_val("pers2_failB", failB, 32'h0);
        drive(8'h00, 8'hFF, 8'h00, 1'b0, 1'b0);
        check_val("gap_errB", errB, 32'h0);
        check_val("gap_cntB", cntB, 32'd2);
        check_val("gap_out", out, 32'h00);
        drive(8'h00, 8'hFF, 8'h00, 1'b1, 1'b0);
        check_val("pers3_cntB", cntB, 32'd3);
        check_val("pers3_failB", failB, 32'h0);
        drive(8'h00, 8'hFF, 8'h00, 1'b1, 1'b0);
        check_val("pers4_cntB", cntB, 32'd4);
        check_val("pers4_failB", failB, 32'h1);
        check_val("pers4_out", out, 32'h00);
        drive(8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
        check_val("sticky_failB", failB, 32'h1);
        check_val("sticky_errB", errB, 32'h0);
        check_val("sticky_cntB", cntB, 32'd4);

        // Lane A run restarted after the earlier clean cycle: 3 more mismatches stay below 4
        for (int i = 0; i < 3; i++) begin
            drive(8'h01, 8'h00, 8'h00, 1'b1, 1'b0);
        end
        check_val("runA3_cntA", cntA, 32'd4);
        check_val("runA3_failA", failA, 32'h0);
        drive(8'h01, 8'h00, 8'h00, 1'b1, 1'b0);
        check_val("runA4_failA", failA, 32'h1);
        check_val("runA4_cntA", cntA, 32'd5);

        // Clear
        drive(8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
        check_val("clr_cnts", {cntA, cntB, cntC}, 32'h0);
        check_val("clr_fails", {failA, failB, failC}, 32'h0);

        // Multi-lane
        drive(8'h01, 8'h02, 8'h00, 1'b1, 1'b0);
        check_val("multi_out", out, 32'h00);
        check_val("multi_errs", {errA, errB, errC, multi_err}, 32'b1101);
        check_val("multi_cnts", {cntA, cntB, cntC}, 32'h010100);

        // Saturation and clear during mismatch
        drive(8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            drive(8'h00, 8'h00, 8'h0F, 1'b1, 1'b0);
            check_val($sformatf("sat%0d_u2_cntC", i), u2_cntC, (i < 3) ? i : 3);
            check_val($sformatf("sat%0d_u2_failC", i), u2_failC, 32'h1);
            check_val($sformatf("sat%0d_cntC", i), cntC, i);
            check_val($sformatf("sat%0d_failC", i), failC, (i >= 4) ? 1 : 0);
        end
        drive(8'h00, 8'h00, 8'h0F, 1'b1, 1'b1);
        check_val("clrmis_u2_cntC", u2_cntC, 32'h0);
        check_val("clrmis_u2_failC", u2_failC, 32'h0);
        check_val("clrmis_u2_errC", u2_errC, 32'h1);
        check_val("clrmis_cntC", cntC, 32'h0);
        check_val("clrmis_failC", failC, 32'h0);
        check_val("clrmis_errC", errC, 32'h1);
        check_val("clrmis_out_valid", out_valid, 32'h1);

        // Reset mid-operation discards in-flight data
        rst = 1'b1;
        drive(8'hAA, 8'hAA, 8'h55, 1'b1, 1'b0);
        check_val("rstmid_out", out, 32'h0);
        check_val("rstmid_flags", {out_valid, errA, errB, errC, multi_err}, 32'h0);
        rst = 1'b0;
        drive(8'hAA, 8'hAA, 8'h55, 1'b1, 1'b0);
        check_val("post_rst_out", out, 32'hAA);
        check_val("post_rst_cntC", cntC, 32'd1);
`ifdef TMR_VOTER_FANOUT_EN
        check_val("fanout", {outA, outB, outC}, 32'hAAAAAA);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
